pbit_local_field: RTL and testbench

//  Upstream stage of the pbit: computes the local field z = bias + sum_j W[j]*m[j]
//  for one p-bit from its N_NEIGH neighbour states, in signed fixed point Q(INT_SIZE).(FLOAT_SIZE).

---
 rtl/pbit_local_field_pkg.sv | 26 ++
 rtl/pbit_local_field_if.sv | 33 +++
 rtl/pbit_local_field_sat.sv | 39 +++
 rtl/pbit_local_field.sv | 132 +++++++++++++
 tb/tb_pbit_local_field.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pbit_local_field_pkg.sv
// Shared fixed-point types, constants and FSM encoding for the pbit pipeline stages.
// Word format is signed Q(INT_SIZE).(FLOAT_SIZE).
package pbit_pkg;

    localparam int INT_SIZE   = 8;
    localparam int FLOAT_SIZE = 24;
    localparam int DW         = INT_SIZE + FLOAT_SIZE;

    typedef logic signed [DW-1:0] fixed_t;

    localparam fixed_t FIX_ONE = fixed_t'(1 << FLOAT_SIZE);
    localparam fixed_t FIX_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam fixed_t FIX_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    // Index width for a table of n entries; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pbit_local_field_if.sv
// Request/result and weight-load bundle between a pbit local-field stage and its host.
// master = host side, slave = field engine side.
interface pbit_local_field_if
    import pbit_pkg::*;
#(
    parameter int N_NEIGH = 8,
    parameter int DW      = pbit_pkg::DW
);

    localparam int IW = idx_width(N_NEIGH);

    logic                  start;
    logic [N_NEIGH-1:0]    m_vec;
    logic signed [DW-1:0]  bias;
    logic                  w_we;
    logic [IW-1:0]         w_waddr;
    logic signed [DW-1:0]  w_wdata;
    logic                  busy;
    logic signed [DW-1:0]  z;
    logic                  z_valid;
    logic                  wr_drop;

    modport master (
        output start, m_vec, bias, w_we, w_waddr, w_wdata,
        input  busy, z, z_valid, wr_drop
    );

    modport slave (
        input  start, m_vec, bias, w_we, w_waddr, w_wdata,
        output busy, z, z_valid, wr_drop
    );

endinterface

// File: rtl/pbit_local_field_sat.sv
// Width-reducing signed saturator: clamps IN_W-bit input to the OUT_W-bit signed range.
// Narrower inputs are simply sign-extended.
module fixed_sat #(
    parameter int IN_W  = 37,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    generate
        if (IN_W > OUT_W) begin : g_reduce
            localparam int HW = IN_W - OUT_W + 1;

            // The value fits when every bit above the output sign bit matches it.
            logic [HW-1:0] head;
            logic          fits;

            assign head = din[IN_W-1:OUT_W-1];
            assign fits = (head == {HW{1'b0}}) || (head == {HW{1'b1}});

            always_comb begin
                dout = din[OUT_W-1:0];
                if (!fits) begin
                    if (din[IN_W-1]) begin
                        dout = {1'b1, {(OUT_W-1){1'b0}}};
                    end else begin
                        dout = {1'b0, {(OUT_W-1){1'b1}}};
                    end
                end
            end
        end else if (IN_W == OUT_W) begin : g_pass
            assign dout = din;
        end else begin : g_extend
            assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
        end
    endgenerate

endmodule

// File: rtl/pbit_local_field.sv
// Local field z = bias + sum_j (m[j] ? W[j] : -W[j]) for one p-bit, one neighbour per clock,
// saturated to the word width and held until the next update.
module pbit_local_field #(
    parameter int N_NEIGH    = 8,
    parameter int INT_SIZE   = pbit_pkg::INT_SIZE,
    parameter int FLOAT_SIZE = pbit_pkg::FLOAT_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    pbit_local_field_if.slave bus
);

    import pbit_pkg::*;

    localparam int DW = INT_SIZE + FLOAT_SIZE;
    localparam int IW = idx_width(N_NEIGH);
    // Guard bits make the worst-case sum of N_NEIGH+1 full-scale terms exact.
    localparam int AW = DW + $clog2(N_NEIGH + 1) + 1;

    localparam logic [IW:0]   N_LIM    = (IW+1)'(N_NEIGH);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_NEIGH - 1);

    state_t                 state_reg, state_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic [N_NEIGH-1:0]     m_reg, m_next;
    logic signed [AW-1:0]   acc_reg, acc_next;
    logic signed [DW-1:0]   z_reg, z_next;
    logic                   z_valid_reg, z_valid_next;
    logic                   wr_drop_reg, wr_drop_next;

    logic [N_NEIGH-1:0][DW-1:0] w_rd;
    logic signed [DW-1:0]       w_cur;
    logic signed [AW-1:0]       w_ext;
    logic signed [AW-1:0]       bias_ext;
    logic signed [DW-1:0]       z_sat;
    logic                       w_addr_ok;
    logic                       w_wr_en;

    // Weights only change while idle so an in-flight sum sees a stable table.
    assign w_addr_ok = {1'b0, bus.w_waddr} < N_LIM;
    assign w_wr_en   = bus.w_we && (state_reg == IDLE) && w_addr_ok;

    generate
        for (genvar gi = 0; gi < N_NEIGH; gi++) begin : g_weight
            logic [DW-1:0] w_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_reg <= '0;
                end else if (w_wr_en && (bus.w_waddr == IW'(gi))) begin
                    w_reg <= bus.w_wdata;
                end
            end

            assign w_rd[gi] = w_reg;
        end
    endgenerate

    assign w_cur    = $signed(w_rd[idx_reg]);
    assign w_ext    = {{(AW-DW){w_cur[DW-1]}}, w_cur};
    assign bias_ext = {{(AW-DW){bus.bias[DW-1]}}, bus.bias};

    fixed_sat #(
        .IN_W  (AW),
        .OUT_W (DW)
    ) u_sat (
        .din  (acc_reg),
        .dout (z_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            m_reg       <= '0;
            acc_reg     <= '0;
            z_reg       <= '0;
            z_valid_reg <= 1'b0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            m_reg       <= m_next;
            acc_reg     <= acc_next;
            z_reg       <= z_next;
            z_valid_reg <= z_valid_next;
            wr_drop_reg <= wr_drop_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        m_next       = m_reg;
        acc_next     = acc_reg;
        z_next       = z_reg;
        z_valid_next = 1'b0;
        wr_drop_next = bus.w_we && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    m_next     = bus.m_vec;
                    acc_next   = bias_ext;
                    idx_next   = '0;
                    state_next = ACC;
                end
            end
            ACC: begin
                acc_next = m_reg[idx_reg] ? (acc_reg + w_ext) : (acc_reg - w_ext);
                idx_next = idx_reg + IW'(1);
                if (idx_reg == IDX_LAST) begin
                    state_next = SAT;
                end
            end
            SAT: begin
                z_next       = z_sat;
                z_valid_next = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.z       = z_reg;
    assign bus.z_valid = z_valid_reg;
    assign bus.wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_pbit_local_field.sv
// Directed bench for pbit_local_field with N_NEIGH=8: hand-computed fields, latency,
// saturation, back-to-back starts, weight-write rules and mid-run reset.
module tb_pbit_local_field;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pbit_local_field_if #(.N_NEIGH(8), .DW(32)) bus ();

    pbit_local_field #(.N_NEIGH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives all eight weights with one value, one write per cycle.
    task automatic load_all(input logic [31:0] v);
        for (int j = 0; j < 8; j++) begin
            bus.w_we    = 1'b1;
            bus.w_waddr = 3'(j);
            bus.w_wdata = v;
            @(negedge clk);
        end
        bus.w_we = 1'b0;
    endtask

    task automatic start_calc(input logic [7:0] m, input logic [31:0] b);
        bus.start = 1'b1;
        bus.m_vec = m;
        bus.bias  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Cycles until z_valid is seen, or -1 if it never comes within the budget.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.z_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.m_vec   = '0;
        bus.bias    = '0;
        bus.w_we    = 1'b0;
        bus.w_waddr = '0;
        bus.w_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.z !== 32'h0) begin errors++; $display("FAIL reset_z: got %h expected 00000000", bus.z); end
        checks++;
        if (bus.z_valid !== 1'b0) begin errors++; $display("FAIL reset_z_valid: got %b expected 0", bus.z_valid); end
        checks++;
        if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b expected 0", bus.wr_drop); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b z=%h z_valid=%b", bus.busy, bus.z, bus.z_valid);
    endtask

    task automatic test_sum_positive;
        int lat;
        load_all(32'h0100_0000);
        start_calc(8'hFF, 32'h0);
        // Inputs changed after capture must not disturb the computation.
        bus.m_vec = 8'h00;
        bus.bias  = 32'h1234_5678;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL pos_busy_after_start: got %b expected 1", bus.busy); end
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL pos_latency: got %0d expected 9", lat); end
        checks++;
        if (bus.z !== 32'h0800_0000) begin errors++; $display("FAIL pos_z: got %h expected 08000000", bus.z); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL pos_busy_at_valid: got %b expected 0", bus.busy); end
        @(negedge clk);
        checks++;
        if (bus.z_valid !== 1'b0) begin errors++; $display("FAIL pos_valid_pulse: got %b expected 0", bus.z_valid); end
        checks++;
        if (bus.z !== 32'h0800_0000) begin errors++; $display("FAIL pos_z_hold: got %h expected 08000000", bus.z); end
        $display("sum_positive: m=ff bias=0 lat=%0d z=%h", lat, bus.z);
    endtask

    task automatic test_sum_negative;
        int lat;
        start_calc(8'h00, 32'h0080_0000);
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL neg_latency: got %0d expected 9", lat); end
        checks++;
        if (bus.z !== 32'hF880_0000) begin errors++; $display("FAIL neg_z: got %h expected f8800000", bus.z); end
        $display("sum_negative: m=00 bias=00800000 lat=%0d z=%h", lat, bus.z);
    endtask

    task automatic test_saturation;
        int lat;
        load_all(32'h6400_0000);
        start_calc(8'hFF, 32'h0);
        wait_valid(lat);
        checks++;
        if (bus.z !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos_z: got %h expected 7fffffff", bus.z); end
        $display("saturation: m=ff lat=%0d z=%h", lat, bus.z);
        start_calc(8'h00, 32'h0);
        wait_valid(lat);
        checks++;
        if (bus.z !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg_z: got %h expected 80000000", bus.z); end
        $display("saturation: m=00 lat=%0d z=%h", lat, bus.z);
    endtask

    task automatic test_back_to_back;
        int   valid_cnt;
        int   first_e;
        int   lat;
        logic [31:0] z_first;
        load_all(32'h0100_0000);
        valid_cnt = 0;
        first_e   = -1;
        z_first   = '0;
        start_calc(8'hFF, 32'h0);
        bus.m_vec = 8'h00;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            if (bus.z_valid === 1'b1) begin
                valid_cnt++;
                first_e = e;
                z_first = bus.z;
            end
            bus.start = (e == 2);
        end
        checks++;
        if (valid_cnt !== 1) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 1", valid_cnt); end
        checks++;
        if (first_e !== 9) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 9", first_e); end
        checks++;
        if (z_first !== 32'h0800_0000) begin errors++; $display("FAIL b2b_first_z: got %h expected 08000000", z_first); end
        $display("back_to_back: first z_valid cycle=%0d count=%0d z=%h", first_e, valid_cnt, z_first);
        // Re-start in the very cycle z_valid is high.
        start_calc(8'h00, 32'h0);
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
        checks++;
        if (bus.z !== 32'hF800_0000) begin errors++; $display("FAIL b2b_second_z: got %h expected f8000000", bus.z); end
        $display("back_to_back: second lat=%0d z=%h", lat, bus.z);
    endtask

    task automatic test_weight_write;
        int lat;
        start_calc(8'hFF, 32'h0);
        @(negedge clk);
        bus.w_we    = 1'b1;
        bus.w_waddr = 3'd0;
        bus.w_wdata = 32'h6400_0000;
        @(negedge clk);
        bus.w_we = 1'b0;
        checks++;
        if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL wdrop_pulse: got %b expected 1", bus.wr_drop); end
        @(negedge clk);
        checks++;
        if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL wdrop_clear: got %b expected 0", bus.wr_drop); end
        wait_valid(lat);
        checks++;
        if (bus.z !== 32'h0800_0000) begin errors++; $display("FAIL wdrop_result: got %h expected 08000000", bus.z); end
        $display("weight_write: dropped write, z=%h", bus.z);
        start_calc(8'hFF, 32'h0);
        wait_valid(lat);
        checks++;
        if (bus.z !== 32'h0800_0000) begin errors++; $display("FAIL wdrop_table_kept: got %h expected 08000000", bus.z); end
        // Write of W[0]=-1.0 together with start: the new weight must be used.
        bus.w_we    = 1'b1;
        bus.w_waddr = 3'd0;
        bus.w_wdata = 32'hFF00_0000;
        bus.start   = 1'b1;
        bus.m_vec   = 8'hFF;
        bus.bias    = 32'h0;
        @(negedge clk);
        bus.w_we  = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL wr_start_no_drop: got %b expected 0", bus.wr_drop); end
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL wr_start_latency: got %0d expected 9", lat); end
        checks++;
        if (bus.z !== 32'h0600_0000) begin errors++; $display("FAIL wr_start_z: got %h expected 06000000", bus.z); end
        $display("weight_write: write+start lat=%0d z=%h", lat, bus.z);
    endtask

    task automatic test_reset_abort;
        int lat;
        int valid_cnt;
        valid_cnt = 0;
        start_calc(8'hFF, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.z !== 32'h0) begin errors++; $display("FAIL abort_z: got %h expected 00000000", bus.z); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.z_valid === 1'b1) valid_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.z_valid === 1'b1) valid_cnt++;
        end
        checks++;
        if (valid_cnt !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", valid_cnt); end
        $display("reset_abort: busy=%b z=%h stray_valids=%0d", bus.busy, bus.z, valid_cnt);
        // Weights were cleared by reset, so the field is just the zero bias.
        start_calc(8'hFF, 32'h0);
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL rerun_latency: got %0d expected 9", lat); end
        checks++;
        if (bus.z !== 32'h0) begin errors++; $display("FAIL rerun_z: got %h expected 00000000", bus.z); end
        $display("reset_abort: rerun lat=%0d z=%h", lat, bus.z);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sum_positive();
        test_sum_negative();
        test_saturation();
        test_back_to_back();
        test_weight_write();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
